vga_stream_out: RTL and testbench
=================================

# vga_stream_out

Parametrised VGA output engine that replaces the fixed 640x480 VGA interface of the Qsys system. It accepts a pixel stream with start-of-frame markers, buffers it in an internal FIFO, generates programmable horizontal/vertical timing and drives the ADV7123-style DAC pins. Unlike the fixed core, it re-aligns to the stream after underflow or frame misalignment and reports both conditions.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync in lines
- HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low)
- COLOR_BITS, 8, bits per colour channel, 1..10
- FIFO_DEPTH, 16, pixel FIFO entries, power of two, 4 or more

Ports:
- clk_clk  in  1  pixel clock
- reset_reset_n  in  1  asynchronous, active-low reset
- in_data  in  3*COLOR_BITS  pixel {R,G,B}, R in the MSBs
- in_sop  in  1  first pixel of a frame
- in_valid  in  1  pixel offered
- in_ready  out  1  FIFO not full
- vga_CLK  out  1  DAC clock, ~clk_clk
- vga_HS, vga_VS  out  1  syncs, polarity per HS_POL/VS_POL
- vga_BLANK  out  1  active-low blank (1 = visible pixel)
- vga_SYNC  out  1  constant 0
- vga_R, vga_G, vga_B  out  COLOR_BITS each  colour
- frame_start  out  1  one-cycle pulse when pixel (0,0) is driven
- underflow, sync_err  out  1  sticky error flags
- err_clear  in  1  clears both sticky flags

## Operation
- Counters: h_cnt over 0..H_TOTAL-1 with H_TOTAL = sum of H_*, and v_cnt over 0..V_TOTAL-1. v_cnt advances when h_cnt wraps. Order within each period: active, front porch, sync, back porch.
- active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE). HS is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS is asserted the same way on v_cnt, for whole lines.
- FIFO: width 3*COLOR_BITS+1 (sop stored). A push happens on in_valid & in_ready. in_ready = count < FIFO_DEPTH.
- FSM with states RESYNC and RUN. Reset state is RESYNC.
- RESYNC:
  - Non-sop FIFO heads are popped and discarded every cycle.
  - A sop head is held. At (h,v) = (0,0) with a sop head, go to RUN and display that pixel.
  - All active pixels output 0.
- RUN:
  - One pop per active cycle.
  - Empty FIFO on an active cycle: output 0, set underflow, go to RESYNC.
  - At (0,0) with a non-sop head: set sync_err, output 0, go to RESYNC.
  - A sop head at any other active position: set sync_err, output 0, go to RESYNC without popping it.
- Blanked cycles output RGB = 0.
- Error flags: err_clear clears them. A set event in the same cycle wins over err_clear.

## Timing
- Reset values: HS = ~HS_POL, VS = ~VS_POL, BLANK = 0, RGB = 0, frame_start = 0, flags = 0, in_ready = 0. The counters restart at (0,0).
- All VGA outputs are registered. The output in cycle n+1 reflects counter state n, so pixel latency from pop to pins is 1 clock.
- A word written in cycle n is poppable in cycle n+1. A push into a full FIFO is never accepted. A simultaneous push and pop while full is refused; in_ready is the registered full state.
- frame_start rises in the same cycle that the pins show pixel (0,0), only in RUN.
- Reset asserted mid-frame: outputs go to their reset values asynchronously and the FIFO empties. After release, the first frame is displayed only once a sop is at the head at (0,0).

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - Adds input pattern_sel (1 bit).
  - With pattern_sel = 1, active pixels show 8 vertical colour bars of width H_ACTIVE/8, in the order white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or 0.
  - In pattern mode the FIFO keeps accepting and discarding, the FSM is forced to RESYNC, and no error flags are set.
- Undefined: no pattern_sel port and no pattern logic.

## Test plan
Small timing for simulation: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, FIFO_DEPTH=4.
- Reset: hold reset_reset_n = 0 -> HS = VS = 1, BLANK = 0, RGB = 0, in_ready = 0. After release, in_ready = 1 next cycle.
- Free-running counters: measure the syncs -> HS low 2 of every 8 clocks, VS low for 1 of every 6 lines, BLANK high 4 clocks per visible line.
- Nominal frame: stream 12 pixels 0x000001..0x00000C, sop on the first -> pins show them in order on the visible positions, frame_start with pixel 1, no flags.
- Underflow: supply only 5 pixels -> pixel 6 shows 0, underflow = 1, later frame pixels 0. The next sop-led frame displays correctly.
- Misalignment: 3 junk pixels without sop, then a sop frame -> junk is discarded in RESYNC, the sop frame displays from (0,0), sync_err stays 0. A mid-frame sop sets sync_err = 1.
- err_clear pulse after the errors -> both flags read 0 on the next clock.

Source files
------------

// File: rtl/vga_stream_out.sv
// VGA output engine: buffers a sop-marked pixel stream, generates programmable timing and
// re-aligns to the stream after underflow or misalignment. Define VGA_TEST_PATTERN_EN for colour bars.
module vga_stream_out #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   COLOR_BITS = 8,
  parameter int   FIFO_DEPTH = 16
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [3*COLOR_BITS-1:0] in_data,
  input  logic                    in_sop,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    vga_CLK,
  output logic                    vga_HS,
  output logic                    vga_VS,
  output logic                    vga_BLANK,
  output logic                    vga_SYNC,
  output logic [COLOR_BITS-1:0]   vga_R,
  output logic [COLOR_BITS-1:0]   vga_G,
  output logic [COLOR_BITS-1:0]   vga_B,
  output logic                    frame_start,
  output logic                    underflow,
  output logic                    sync_err,
  input  logic                    err_clear
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic                    pattern_sel
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int PW = 3 * COLOR_BITS;
  localparam int DW = PW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] S_RESYNC = 1'b0;
  localparam logic [0:0] S_RUN    = 1'b1;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [0:0]    state, state_next;
  logic          push, pop, head_valid, head_sop;
  logic [PW-1:0] head_data, pix;
  logic          active, at_origin, set_uf, set_se, show_origin;

  assign vga_CLK    = ~clk_clk;
  assign vga_SYNC   = 1'b0;
  assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign at_origin  = (h_cnt == '0) && (v_cnt == '0);
  assign push       = in_valid & in_ready;
  assign head_valid = (count != '0);
  assign {head_sop, head_data} = mem[rd_ptr];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= {in_sop, in_data};
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  // in_ready is registered so a full FIFO refuses the word even when a pop happens alongside.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      in_ready <= (count_next < DEPTH);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [2:0]    bar;
  logic [PW-1:0] bar_rgb;

  // Bars white..black map to RGB = ~{idx[1], idx[2], idx[0]}.
  always_comb begin
    bar = 3'd7;
    if (int'(h_cnt) / BAR_W < 8) bar = 3'(int'(h_cnt) / BAR_W);
    bar_rgb = {{COLOR_BITS{~bar[1]}}, {COLOR_BITS{~bar[2]}}, {COLOR_BITS{~bar[0]}}};
  end
`endif

  // A mismatch between "at (0,0)" and "head carries sop" means the stream and timing disagree.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    pix         = '0;
    set_uf      = 1'b0;
    set_se      = 1'b0;
    show_origin = 1'b0;
    if (state == S_RESYNC) begin
      if (head_valid && !head_sop) begin
        pop = 1'b1;
      end else if (head_valid && at_origin) begin
        pop         = 1'b1;
        pix         = head_data;
        show_origin = 1'b1;
        state_next  = S_RUN;
      end
    end else if (active) begin
      if (!head_valid) begin
        set_uf     = 1'b1;
        state_next = S_RESYNC;
      end else if (at_origin != head_sop) begin
        set_se     = 1'b1;
        state_next = S_RESYNC;
      end else begin
        pop         = 1'b1;
        pix         = head_data;
        show_origin = at_origin;
      end
    end
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel) begin
      state_next  = S_RESYNC;
      pop         = head_valid;
      pix         = active ? bar_rgb : '0;
      set_uf      = 1'b0;
      set_se      = 1'b0;
      show_origin = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= S_RESYNC;
      vga_HS      <= ~HS_POL;
      vga_VS      <= ~VS_POL;
      vga_BLANK   <= 1'b0;
      vga_R       <= '0;
      vga_G       <= '0;
      vga_B       <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_next;
      vga_HS      <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
      vga_VS      <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;
      vga_BLANK   <= active;
      {vga_R, vga_G, vga_B} <= pix;
      frame_start <= show_origin;
      underflow   <= set_uf | (underflow & ~err_clear);
      sync_err    <= set_se | (sync_err & ~err_clear);
    end
  end

endmodule

// File: tb/tb_vga_stream_out.sv
// Self-checking bench for vga_stream_out: directed scenarios plus random streaming,
// compared every cycle against a queue-based reference derived from absolute cycle time.
module tb_vga_stream_out;

  localparam int CB = 8;
  localparam int HA = 4, HFP = 1, HSY = 2, HBP = 1;
  localparam int VA = 3, VFP = 1, VSY = 1, VBP = 1;
  localparam int DEPTH = 4;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        sop;
    logic [23:0] data;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3*CB-1:0] in_data = '0;
  logic          in_sop = 1'b0, in_valid = 1'b0, err_clear = 1'b0;
  logic          in_ready, vga_CLK, vga_HS, vga_VS, vga_BLANK, vga_SYNC;
  logic [CB-1:0] vga_R, vga_G, vga_B;
  logic          frame_start, underflow, sync_err;

  always #5 clk = ~clk;

  vga_stream_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_BITS(CB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .in_data(in_data), .in_sop(in_sop), .in_valid(in_valid), .in_ready(in_ready),
    .vga_CLK(vga_CLK), .vga_HS(vga_HS), .vga_VS(vga_VS), .vga_BLANK(vga_BLANK),
    .vga_SYNC(vga_SYNC), .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
    .frame_start(frame_start), .underflow(underflow), .sync_err(sync_err),
    .err_clear(err_clear)
  );

  int   t, checks, errors;
  pix_t src[$];
  pix_t fifo_q[$];
  bit   displaying, m_ready, m_uf, m_se;
  bit   gappy, clr_req;
  logic e_hs, e_vs, e_blank, e_fs;
  logic [23:0] e_rgb;
  int   hs_low, vs_low, blank_hi, fs_cnt;
  logic [23:0] seen[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s t=%0d observed=0x%0h expected=0x%0h", tag, t, obs, exp);
    end
  endtask

  function automatic void model_reset();
    t = 0;
    fifo_q.delete();
    displaying = 1'b0;
    m_ready = 1'b0;
    m_uf = 1'b0;
    m_se = 1'b0;
  endfunction

  // Reference: position comes from absolute cycle time; the buffer is a plain queue.
  function automatic void model_step(input bit valid, input pix_t word, input bit clr);
    int h, v;
    bit vis, origin, have, uf_set, se_set, fs;
    pix_t head;
    logic [23:0] shown;
    h = t % HT;
    v = (t / HT) % VT;
    vis = (h < HA) && (v < VA);
    origin = (t % FRAME) == 0;
    have = fifo_q.size() > 0;
    head = have ? fifo_q[0] : '0;
    shown = '0;
    fs = 1'b0;
    uf_set = 1'b0;
    se_set = 1'b0;
    if (!displaying) begin
      if (have && !head.sop) begin
        void'(fifo_q.pop_front());
      end else if (have && origin) begin
        void'(fifo_q.pop_front());
        shown = head.data;
        fs = 1'b1;
        displaying = 1'b1;
      end
    end else if (vis) begin
      if (!have) begin
        uf_set = 1'b1;
        displaying = 1'b0;
      end else if ((head.sop && !origin) || (!head.sop && origin)) begin
        se_set = 1'b1;
        displaying = 1'b0;
      end else begin
        void'(fifo_q.pop_front());
        shown = head.data;
        fs = origin;
      end
    end
    if (valid && m_ready) fifo_q.push_back(word);
    m_ready = fifo_q.size() < DEPTH;
    e_hs = !(h >= HA + HFP && h < HA + HFP + HSY);
    e_vs = !(v >= VA + VFP && v < VA + VFP + VSY);
    e_blank = vis;
    e_rgb = shown;
    e_fs = fs;
    m_uf = uf_set | (m_uf & !clr);
    m_se = se_set | (m_se & !clr);
  endfunction

  task automatic applyStimulus();
    pix_t word;
    bit valid;
    valid = (src.size() > 0) && (!gappy || $urandom_range(3) != 0);
    if (valid) begin
      word = src[0];
    end else begin
      word.sop = 1'($urandom_range(1));
      word.data = 24'($urandom);
    end
    in_valid = valid;
    in_sop = word.sop;
    in_data = word.data;
    err_clear = clr_req;
    if (valid && m_ready) void'(src.pop_front());
    model_step(valid, word, clr_req);
    @(posedge clk);
    @(negedge clk);
    t++;
    checkOutput("HS", vga_HS, e_hs);
    checkOutput("VS", vga_VS, e_vs);
    checkOutput("BLANK", vga_BLANK, e_blank);
    checkOutput("RGB", {vga_R, vga_G, vga_B}, e_rgb);
    checkOutput("frame_start", frame_start, e_fs);
    checkOutput("underflow", underflow, m_uf);
    checkOutput("sync_err", sync_err, m_se);
    checkOutput("in_ready", in_ready, m_ready);
    checkOutput("vga_SYNC", vga_SYNC, 0);
  endtask

  task automatic load_frame(input int n, input bit lead_sop, input bit seq);
    for (int i = 0; i < n; i++) begin
      pix_t p;
      p.sop = lead_sop && (i == 0);
      p.data = seq ? 24'(i + 1) : 24'($urandom);
      src.push_back(p);
    end
  endtask

  task automatic run_until(input int stop_t);
    while (t < stop_t) applyStimulus();
  endtask

  task automatic check_reset_values(input string phase);
    checkOutput({phase, "_HS"}, vga_HS, 1);
    checkOutput({phase, "_VS"}, vga_VS, 1);
    checkOutput({phase, "_BLANK"}, vga_BLANK, 0);
    checkOutput({phase, "_RGB"}, {vga_R, vga_G, vga_B}, 0);
    checkOutput({phase, "_in_ready"}, in_ready, 0);
    checkOutput({phase, "_frame_start"}, frame_start, 0);
    checkOutput({phase, "_underflow"}, underflow, 0);
    checkOutput({phase, "_sync_err"}, sync_err, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    gappy = 1'b0;
    clr_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    checkOutput("vga_CLK_inverted", vga_CLK, 1);

    // Free-running timing over one idle frame.
    rst_n = 1'b1;
    hs_low = 0;
    vs_low = 0;
    blank_hi = 0;
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus();
      if (i == 0) checkOutput("in_ready_after_release", in_ready, 1);
      if (vga_HS == 1'b0) hs_low++;
      if (vga_VS == 1'b0) vs_low++;
      if (vga_BLANK == 1'b1) blank_hi++;
    end
    checkOutput("hs_low_clocks", hs_low, 12);
    checkOutput("vs_low_clocks", vs_low, 8);
    checkOutput("blank_high_clocks", blank_hi, 12);

    // Nominal frame 1..12: held in RESYNC until the next (0,0).
    load_frame(12, 1'b1, 1'b1);
    fs_cnt = 0;
    while (t < 120) begin
      applyStimulus();
      if (t > 2 * FRAME && vga_BLANK) seen.push_back({vga_R, vga_G, vga_B});
      if (frame_start) fs_cnt++;
    end
    checkOutput("nominal_frame_start_count", fs_cnt, 1);
    checkOutput("nominal_pixel_count", seen.size(), 12);
    for (int i = 0; i < seen.size() && i < 12; i++)
      checkOutput("nominal_pixel", seen[i], i + 1);
    checkOutput("nominal_underflow", underflow, 0);
    checkOutput("nominal_sync_err", sync_err, 0);

    // Short frame underflows at its 6th pixel, then a full frame recovers.
    load_frame(5, 1'b1, 1'b0);
    run_until(168);
    checkOutput("short_frame_underflow", underflow, 1);
    checkOutput("short_frame_sync_err", sync_err, 0);
    load_frame(12, 1'b1, 1'b0);
    run_until(248);

    // Junk without sop is discarded before a sop-led frame.
    load_frame(3, 1'b0, 1'b0);
    load_frame(12, 1'b1, 1'b0);
    run_until(312);
    checkOutput("junk_discard_sync_err", sync_err, 0);

    // Six-pixel frame followed by a new sop: mid-frame sop.
    load_frame(6, 1'b1, 1'b0);
    load_frame(12, 1'b1, 1'b0);
    run_until(352);
    checkOutput("mid_frame_sop_sync_err", sync_err, 1);
    clr_req = 1'b1;
    applyStimulus();
    clr_req = 1'b0;
    checkOutput("cleared_underflow", underflow, 0);
    checkOutput("cleared_sync_err", sync_err, 0);

    // Random streaming with gaps, missing sops and clear pulses.
    gappy = 1'b1;
    while (t < 800) begin
      if (src.size() < 3) load_frame($urandom_range(14, 3), $urandom_range(3) != 0, 1'b0);
      clr_req = ($urandom_range(40) == 0);
      applyStimulus();
    end
    clr_req = 1'b0;
    gappy = 1'b0;

    // Reset mid-frame, then re-acquire a sop frame.
    #2 rst_n = 1'b0;
    #1 check_reset_values("midframe_reset");
    src.delete();
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    load_frame(12, 1'b1, 1'b1);
    run_until(110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
